// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and shifter FSM states.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shifter_state_t;

endpackage

// File: rtl/shift_counter.sv
// Loadable down counter for the serial shifter. The load value is clamped
// to N so any over-range shift amount behaves as a full-width shift.
module shift_counter
  import alu_pkg::*;
#(
  parameter int unsigned N  = ALU_WIDTH,
  parameter int unsigned SW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [SW-1:0] amt,
  output logic          last,
  output logic          is_zero
);

  localparam logic [SW-1:0] N_SW = SW'(N);

  logic [SW-1:0] count_q;
  logic [SW-1:0] count_d;

  // Next count: clamped load takes priority, otherwise decrement toward zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = (amt > N_SW) ? N_SW : amt;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - SW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last    = (count_q == SW'(1));
  assign is_zero = (count_q == '0);

endmodule

// File: rtl/serial_left_shifter.sv
// Multi-cycle logical left shifter: one bit position per clock with a
// start/ready/done handshake, reporting the last bit shifted out.
module serial_left_shifter
  import alu_pkg::*;
#(
  parameter int unsigned N  = ALU_WIDTH,
  parameter int unsigned SW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] shamt,
  output logic          ready,
  output logic          done,
  output logic [N-1:0]  y,
  output logic          carry,
  output logic          zero
);

  shifter_state_t state_q;
  logic [N-1:0]   y_q;
  logic           carry_q;
  logic           ready_q;
  logic           done_q;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_last;
  logic cnt_zero;

  assign cnt_load = (state_q == IDLE) && start;
  assign cnt_dec  = (state_q == SHIFT);

  shift_counter #(
    .N  (N),
    .SW (SW)
  ) u_shift_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .dec     (cnt_dec),
    .amt     (shamt),
    .last    (cnt_last),
    .is_zero (cnt_zero)
  );

  // Control FSM and shift register; ready/done are registered with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      carry_q <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            y_q     <= a;
            carry_q <= 1'b0;
            ready_q <= 1'b0;
            // Clamping never maps a nonzero amount to zero, so shamt==0
            // alone decides whether a shift phase is needed.
            if (shamt == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          carry_q <= y_q[N-1];
          y_q     <= {y_q[N-2:0], 1'b0};
          // is_zero is a guard only; a loaded nonzero count always hits last.
          if (cnt_last || cnt_zero) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign y     = y_q;
  assign carry = carry_q;
  assign zero  = (y_q == '0);

endmodule

// File: tb/tb_serial_left_shifter.sv
// Testbench for serial_left_shifter: arithmetic reference model checked every
// cycle, plus directed operations with hand-computed results.
module tb_serial_left_shifter;

  localparam int unsigned N  = 4;
  localparam int unsigned SW = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic [N-1:0]  a;
  logic [SW-1:0] shamt;
  logic          ready;
  logic          done;
  logic [N-1:0]  y;
  logic          carry;
  logic          zero;

  int tests = 0;
  int fails = 0;

  serial_left_shifter #(
    .N  (N),
    .SW (SW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .shamt (shamt),
    .ready (ready),
    .done  (done),
    .y     (y),
    .carry (carry),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the operand, effective amount and the number of shifts applied so
  // far; outputs are derived arithmetically from those.
  logic         m_ready = 1'b1;
  logic         m_done  = 1'b0;
  logic [N-1:0] m_a     = '0;
  int           m_eff   = 0;
  int           m_j     = 0;

  function automatic int clampf(input logic [SW-1:0] s);
    return (int'(s) > int'(N)) ? int'(N) : int'(s);
  endfunction

  function automatic logic [N-1:0] model_y(input logic [N-1:0] op, input int j);
    logic [N-1:0] r;
    r = op << j;
    return r;
  endfunction

  function automatic logic model_c(input logic [N-1:0] op, input int j);
    logic [N-1:0] r;
    if (j == 0) return 1'b0;
    r = op >> (int'(N) - j);
    return r[0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ready <= 1'b1;
      m_done  <= 1'b0;
      m_a     <= '0;
      m_eff   <= 0;
      m_j     <= 0;
    end else if (m_done) begin
      m_done  <= 1'b0;
      m_ready <= 1'b1;
    end else if (m_ready) begin
      if (start) begin
        m_a     <= a;
        m_eff   <= clampf(shamt);
        m_j     <= 0;
        m_ready <= 1'b0;
        m_done  <= (clampf(shamt) == 0);
      end
    end else begin
      m_j <= m_j + 1;
      if (m_j + 1 == m_eff) m_done <= 1'b1;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("m_ready", 32'(ready), 32'(m_ready));
    check("m_done",  32'(done),  32'(m_done));
    check("m_y",     32'(y),     32'(model_y(m_a, m_j)));
    check("m_carry", 32'(carry), 32'(model_c(m_a, m_j)));
    check("m_zero",  32'(zero),  32'(model_y(m_a, m_j) == '0));
  end

  // ---------------- directed stimulus ----------------
  task automatic do_op(input logic [N-1:0] ai, input logic [SW-1:0] si,
                       input logic [N-1:0] ey, input logic ec, input int elat);
    int w;
    int cyc;
    w = 0;
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("wait_ready_timeout", 32'(ready), 32'd1);
    start = 1'b1;
    a     = ai;
    shamt = si;
    @(negedge clk);
    start = 1'b0;
    a     = 4'($urandom);
    shamt = 3'($urandom);
    check("ready_drop", 32'(ready), 32'd0);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(elat));
    check("y_lit", 32'(y), 32'(ey));
    check("carry_lit", 32'(carry), 32'(ec));
    check("zero_lit", 32'(zero), 32'(ey == '0));
  endtask

  initial begin
    int cyc;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    shamt = '0;
    @(negedge clk);
    check("rst_y", 32'(y), 32'h0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_zero", 32'(zero), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Single shift, then idle again
    do_op(4'b0001, 3'd1, 4'b0010, 1'b0, 1);
    @(negedge clk);
    check("ready_after", 32'(ready), 32'd1);

    // Carry out, zero shift, clamp
    do_op(4'b0110, 3'd2, 4'b1000, 1'b1, 2);
    do_op(4'b1010, 3'd0, 4'b1010, 1'b0, 0);
    do_op(4'b1001, 3'd7, 4'b0000, 1'b1, 4);

    // Start mid-shift is ignored
    @(negedge clk);
    start = 1'b1;
    a     = 4'b1111;
    shamt = 3'd3;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b1;
        a     = 4'b0001;
        shamt = 3'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("busy_lat", 32'(cyc), 32'd3);
    check("busy_y", 32'(y), 32'b1000);
    check("busy_carry", 32'(carry), 32'd1);

    // Abort during SHIFT
    @(negedge clk);
    start = 1'b1;
    a     = 4'b1111;
    shamt = 3'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_y", 32'(y), 32'h0);
    check("abort_carry", 32'(carry), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_zero", 32'(zero), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end

    // rst and start together: start dropped
    rst   = 1'b1;
    start = 1'b1;
    a     = 4'b0101;
    shamt = 3'd2;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("rststart_ready", 32'(ready), 32'd1);
      check("rststart_y", 32'(y), 32'h0);
      @(negedge clk);
    end

    // Back-to-back operations
    do_op(4'b0011, 3'd1, 4'b0110, 1'b0, 1);
    do_op(4'b0011, 3'd2, 4'b1100, 1'b0, 2);
    do_op(4'b0011, 3'd3, 4'b1000, 1'b1, 3);
    do_op(4'b0011, 3'd4, 4'b0000, 1'b1, 4);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
